lsu_mem_master: RTL and testbench

- Load/store initiator that drives the core's word-indexed data memory: single-cycle write strobe, combinational read port.
- Accepts one byte/half/word load or store from the execute stage over a valid/ready request channel.
- Performs alignment and range checks, then read-modify-write for sub-word stores and lane extract plus sign/zero extension for loads.
- Returns the result on a valid/ready response channel. Sits between the pipeline MEM stage and the data memory.

---
 rtl/lsu_pkg.sv | 26 ++
 rtl/lsu_align.sv | 55 +++++
 rtl/lsu_mem_master.sv | 210 +++++++++++++++++++++
 tb/tb_lsu_mem_master.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store memory master.
// Optional feature macro: LSU_READBACK_CHECK_EN adds the VERIFY state.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_RANGE    = 2'b10;
  localparam logic [1:0] ERR_SIZE     = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_WRITE  = 3'd3,
    ST_RESP   = 3'd4
`ifdef LSU_READBACK_CHECK_EN
    , ST_VERIFY = 3'd5
`endif
  } state_t;

endpackage

// File: rtl/lsu_align.sv
// Lane handling for the memory master: extracts and extends a load lane from
// a memory word, and merges a sub-word store into the old memory word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_lane,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [15:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Load path: pick the addressed lane and sign/zero extend it.
  always_comb begin
    w_byte = 8'h00;
    case (i_lane)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
    w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];
    case (i_size)
      SZ_B:    o_load = {{24{~i_unsigned & w_byte[7]}}, w_byte};
      SZ_H:    o_load = {{16{~i_unsigned & w_half[15]}}, w_half};
      default: o_load = i_word;
    endcase
  end

  // Store path: replace only the addressed lane of the old word.
  always_comb begin
    o_merged = i_word;
    case (i_size)
      SZ_B: begin
        case (i_lane)
          2'd0:    o_merged[7:0]   = i_wdata[7:0];
          2'd1:    o_merged[15:8]  = i_wdata[7:0];
          2'd2:    o_merged[23:16] = i_wdata[7:0];
          default: o_merged[31:24] = i_wdata[7:0];
        endcase
      end
      SZ_H: begin
        if (i_lane[1]) o_merged[31:16] = i_wdata;
        else           o_merged[15:0]  = i_wdata;
      end
      default: o_merged = i_word;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator between the MEM stage and a word-indexed data memory.
// Optional feature macro: LSU_READBACK_CHECK_EN re-reads each stored word and
// flags a mismatch on resp_rb_err.
//
// state     | meaning
// ----------|---------------------------------------------------------
// ST_IDLE   | ready for a request, checks run on the accept edge
// ST_LOAD   | memory word addressed, lane extracted into resp_rdata
// ST_RMW_RD | old word read for a byte/half store, merge registered
// ST_WRITE  | single write-strobe cycle
// ST_VERIFY | readback of the written word (optional)
// ST_RESP   | response held until resp_ready
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_in,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [1:0]        resp_err_code,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wd,
  input  logic [31:0]       mem_rd
`ifdef LSU_READBACK_CHECK_EN
  ,
  output logic              resp_rb_err
`endif
);

  state_t            r_state;
  logic              r_req_ready;
  logic              r_resp_valid;
  logic [31:0]       r_resp_rdata;
  logic              r_resp_err;
  logic [1:0]        r_err_code;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wd;
  logic [1:0]        r_lane;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic [15:0]       r_wdata;
`ifdef LSU_READBACK_CHECK_EN
  logic              r_rb_err;
`endif

  logic              w_accept;
  logic [ADDR_W-1:0] w_word_idx;
  logic [1:0]        w_chk_code;
  logic [31:0]       w_load;
  logic [31:0]       w_merged;

  assign w_accept   = req_valid & r_req_ready;
  assign w_word_idx = req_addr >> 2;

  // Request checks in priority order: size, alignment, range.
  always_comb begin
    w_chk_code = ERR_NONE;
    if (req_size == SZ_X)
      w_chk_code = ERR_SIZE;
    else if ((req_size == SZ_H && req_addr[0]) ||
             (req_size == SZ_W && req_addr[1:0] != 2'b00))
      w_chk_code = ERR_MISALIGN;
    else if (w_word_idx >= ADDR_W'(DEPTH))
      w_chk_code = ERR_RANGE;
  end

  // The lane unit always looks at the live memory read data; only LOAD and
  // RMW_RD consume its outputs.
  lsu_align u_align (
    .i_word     (mem_rd),
    .i_lane     (r_lane),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .i_wdata    (r_wdata),
    .o_load     (w_load),
    .o_merged   (w_merged)
  );

  // Sequencer with registered outputs; reset abandons any transaction.
  always_ff @(posedge clk) begin
    if (!rst_in) begin
      r_state      <= ST_IDLE;
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
      r_err_code   <= ERR_NONE;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wd     <= '0;
      r_lane       <= '0;
      r_size       <= '0;
      r_unsigned   <= 1'b0;
      r_wdata      <= '0;
`ifdef LSU_READBACK_CHECK_EN
      r_rb_err     <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_req_ready <= 1'b1;
          r_mem_addr  <= '0;
          r_mem_we    <= 1'b0;
          if (w_accept) begin
            r_req_ready <= 1'b0;
            r_lane      <= req_addr[1:0];
            r_size      <= req_size;
            r_unsigned  <= req_unsigned;
            r_wdata     <= req_wdata[15:0];
`ifdef LSU_READBACK_CHECK_EN
            r_rb_err    <= 1'b0;
`endif
            if (w_chk_code != ERR_NONE) begin
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_err_code   <= w_chk_code;
              r_resp_rdata <= '0;
              r_state      <= ST_RESP;
            end else begin
              r_mem_addr <= w_word_idx;
              if (!req_we) begin
                r_state <= ST_LOAD;
              end else if (req_size == SZ_W) begin
                r_mem_we <= 1'b1;
                r_mem_wd <= req_wdata;
                r_state  <= ST_WRITE;
              end else begin
                r_state <= ST_RMW_RD;
              end
            end
          end
        end
        ST_LOAD: begin
          r_resp_rdata <= w_load;
          r_resp_err   <= 1'b0;
          r_err_code   <= ERR_NONE;
          r_resp_valid <= 1'b1;
          r_state      <= ST_RESP;
        end
        ST_RMW_RD: begin
          r_mem_wd <= w_merged;
          r_mem_we <= 1'b1;
          r_state  <= ST_WRITE;
        end
        ST_WRITE: begin
          r_mem_we <= 1'b0;
`ifdef LSU_READBACK_CHECK_EN
          r_state  <= ST_VERIFY;
`else
          r_resp_rdata <= '0;
          r_resp_err   <= 1'b0;
          r_err_code   <= ERR_NONE;
          r_resp_valid <= 1'b1;
          r_state      <= ST_RESP;
`endif
        end
`ifdef LSU_READBACK_CHECK_EN
        ST_VERIFY: begin
          r_rb_err     <= (mem_rd != r_mem_wd);
          r_resp_rdata <= '0;
          r_resp_err   <= 1'b0;
          r_err_code   <= ERR_NONE;
          r_resp_valid <= 1'b1;
          r_state      <= ST_RESP;
        end
`endif
        ST_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
            r_err_code   <= ERR_NONE;
            r_mem_addr   <= '0;
            r_req_ready  <= 1'b1;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready     = r_req_ready;
  assign resp_valid    = r_resp_valid;
  assign resp_rdata    = r_resp_rdata;
  assign resp_err      = r_resp_err;
  assign resp_err_code = r_err_code;
  // Write strobe is also gated by reset so nothing lands in memory during it.
  assign mem_we        = r_mem_we & rst_in;
  assign mem_addr      = r_mem_addr;
  assign mem_wd        = r_mem_wd;
`ifdef LSU_READBACK_CHECK_EN
  assign resp_rb_err   = r_rb_err;
`endif

endmodule

// File: tb/tb_lsu_mem_master.sv
// Self-checking bench for lsu_mem_master: directed cases plus randomized
// traffic against a behavioural memory/request model.
module tb_lsu_mem_master;
  import lsu_pkg::*;

  localparam int DEPTH  = 32;
  localparam int ADDR_W = 32;
  localparam int IW     = $clog2(DEPTH);
`ifdef LSU_READBACK_CHECK_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif

  logic              clk;
  logic              rst_in;
  logic              req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid, resp_ready, resp_err;
  logic [31:0]       resp_rdata;
  logic [1:0]        resp_err_code;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wd, mem_rd;
`ifdef LSU_READBACK_CHECK_EN
  logic              resp_rb_err;
`endif

  lsu_mem_master #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .rst_in        (rst_in),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_size      (req_size),
    .req_unsigned  (req_unsigned),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_rdata    (resp_rdata),
    .resp_err      (resp_err),
    .resp_err_code (resp_err_code),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wd        (mem_wd),
    .mem_rd        (mem_rd)
`ifdef LSU_READBACK_CHECK_EN
    ,
    .resp_rb_err   (resp_rb_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench memory, optional bit-0 corruption on write, preload port.
  logic [31:0] mem [DEPTH];
  logic [31:0] model_mem [DEPTH];
  logic        corrupt_en;
  logic        pl_en;
  logic [IW-1:0] pl_idx;
  logic [31:0] pl_val;

  assign mem_rd = (mem_addr < DEPTH) ? mem[mem_addr[IW-1:0]] : 32'h0;

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_val;
    else if (mem_we && mem_addr < DEPTH) mem[mem_addr[IW-1:0]] <= mem_wd ^ {31'b0, corrupt_en};
  end

  int total = 0;
  int bad = 0;
  int we_total = 0;
  logic        exp_armed;
  logic        exp_err;
  logic        exp_rb;
  logic [1:0]  exp_code;
  logic [31:0] exp_rd;
  logic        last_rb;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, expv, $time);
    end
  endtask

  // ---- behavioural model ----
  function automatic logic [1:0] m_code(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd3) return 2'd3;
    if ((sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0)) return 2'd1;
    if (a / 4 >= DEPTH) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic uns, input logic [31:0] a);
    logic [31:0] w, v;
    w = model_mem[int'(a / 4)];
    if (sz == 2'd0) begin
      v = (w >> (8 * (a % 4))) & 32'hFF;
      if (!uns && v >= 32'h80) v = v + 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v + 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] m_merge(input logic [1:0] sz, input logic [31:0] a,
                                          input logic [31:0] old, input logic [31:0] wd);
    int sh;
    logic [31:0] mask;
    if (sz == 2'd2) return wd;
    if (sz == 2'd0) begin
      sh = 8 * int'(a % 4);
      mask = 32'hFF << sh;
    end else begin
      sh = 16 * int'((a / 2) % 2);
      mask = 32'hFFFF << sh;
    end
    return (old & ~mask) | ((wd << sh) & mask);
  endfunction

  task automatic preload(input int i, input logic [31:0] v);
    pl_en = 1'b1;
    pl_idx = IW'(i);
    pl_val = v;
    model_mem[i] = v;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Per-cycle compare: while a response is presented, it must match the model.
  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      if (mem_we) we_total++;
      if (rst_in && exp_armed && resp_valid) begin
        chk("mon_rdata", resp_rdata, exp_rd);
        chk("mon_err", {31'b0, resp_err}, {31'b0, exp_err});
        chk("mon_code", {30'b0, resp_err_code}, {30'b0, exp_code});
        chk("mon_req_ready", {31'b0, req_ready}, 32'd0);
`ifdef LSU_READBACK_CHECK_EN
        chk("mon_rb_err", {31'b0, resp_rb_err}, {31'b0, exp_rb});
`endif
      end
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int hold, input logic poke,
                        output logic [31:0] rd_o, output logic [1:0] code_o, output int lat_o);
    int guard, lat, exp_lat, we_start, idx;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("req_ready_wait", {31'b0, req_ready}, 32'd1);
    exp_code = m_code(sz, a);
    exp_err  = (exp_code != 2'd0);
    exp_rd   = (!exp_err && !we) ? m_load(sz, uns, a) : 32'h0;
    exp_rb   = we && !exp_err && corrupt_en;
    exp_lat  = exp_err ? 1 : (!we ? 2 : (((sz == 2'd2) ? 2 : 3) + RB));
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    exp_armed = 1'b1;
    we_start = we_total;
    lat = 0;
    do begin
      @(negedge clk);
      if (lat == 0) req_valid = 1'b0;
      lat++;
    end while (!resp_valid && lat < 8);
    chk("latency", lat, exp_lat);
    rd_o = resp_rdata;
    code_o = resp_err_code;
    lat_o = lat;
`ifdef LSU_READBACK_CHECK_EN
    last_rb = resp_rb_err;
`else
    last_rb = 1'b0;
`endif
    for (int h = 0; h < hold; h++) begin
      if (poke) begin
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2;
        req_addr = 32'h0; req_wdata = 32'hFFFF_FFFF;
      end
      @(negedge clk);
      chk("hold_valid", {31'b0, resp_valid}, 32'd1);
      chk("hold_req_ready", {31'b0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    exp_armed = 1'b0;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("after_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("after_req_ready", {31'b0, req_ready}, 32'd1);
    chk("we_pulses", we_total - we_start, (!exp_err && we) ? 1 : 0);
    if (!exp_err && we) begin
      idx = int'(a / 4);
      model_mem[idx] = m_merge(sz, a, model_mem[idx], wd) ^ {31'b0, corrupt_en};
      chk("mem_word", mem[idx], model_mem[idx]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [1:0]  code;
    int          lat;
    int          we_start;
    logic        we;
    logic        uns;
    logic        poke;
    logic [1:0]  sz;
    logic [31:0] a;
    rst_in = 1'b0; resp_ready = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_size = 2'd0; req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    pl_en = 1'b0; pl_idx = '0; pl_val = '0; corrupt_en = 1'b0;
    exp_armed = 1'b0; exp_err = 1'b0; exp_rb = 1'b0; exp_code = '0; exp_rd = '0;
    last_rb = 1'b0;
    fork monitor_loop(); join_none
    @(negedge clk);
    for (int i = 0; i < DEPTH; i++) preload(i, $urandom);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
    chk("rst_code", {30'b0, resp_err_code}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wd", mem_wd, 32'd0);
    rst_in = 1'b1;
    preload(2, 32'h8899_AABB);

    // Directed loads.
    do_req(1'b0, SZ_B, 1'b0, 32'h9, 32'h0, 0, 1'b0, rd, code, lat);
    chk("lb_9_rdata", rd, 32'hFFFF_FFAA);
    chk("lb_9_lat", lat, 2);
    do_req(1'b0, SZ_H, 1'b1, 32'hA, 32'h0, 0, 1'b0, rd, code, lat);
    chk("lhu_a_rdata", rd, 32'h0000_8899);
    do_req(1'b0, SZ_H, 1'b0, 32'hA, 32'h0, 0, 1'b0, rd, code, lat);
    chk("lh_a_rdata", rd, 32'hFFFF_8899);

    // Directed stores.
    do_req(1'b1, SZ_B, 1'b0, 32'hB, 32'h12, 0, 1'b0, rd, code, lat);
    chk("sb_b_mem", mem[2], 32'h1299_AABB);
    chk("sb_b_lat", lat, 3 + RB);
    chk("sb_b_rb", {31'b0, last_rb}, 32'd0);
    do_req(1'b1, SZ_W, 1'b0, 32'h0, 32'hDEAD_BEEF, 0, 1'b0, rd, code, lat);
    chk("sw_0_mem", mem[0], 32'hDEAD_BEEF);
    chk("sw_0_lat", lat, 2 + RB);

    // Error cases and boundaries.
    we_start = we_total;
    do_req(1'b0, SZ_W, 1'b0, 32'h6, 32'h0, 0, 1'b0, rd, code, lat);
    chk("lw_6_code", {30'b0, code}, 32'd1);
    chk("lw_6_lat", lat, 1);
    do_req(1'b1, SZ_W, 1'b0, 32'h80, 32'h1234_5678, 0, 1'b0, rd, code, lat);
    chk("sw_80_code", {30'b0, code}, 32'd2);
    chk("sw_80_lat", lat, 1);
    do_req(1'b1, 2'd3, 1'b0, 32'h0, 32'h5555_5555, 0, 1'b0, rd, code, lat);
    chk("size11_code", {30'b0, code}, 32'd3);
    do_req(1'b0, 2'd3, 1'b0, 32'h81, 32'h0, 0, 1'b0, rd, code, lat);
    chk("size11_prio_code", {30'b0, code}, 32'd3);
    do_req(1'b0, SZ_W, 1'b0, 32'h82, 32'h0, 0, 1'b0, rd, code, lat);
    chk("misalign_prio_code", {30'b0, code}, 32'd1);
    chk("err_no_writes", we_total - we_start, 0);
    do_req(1'b0, SZ_B, 1'b1, 32'h80, 32'h0, 0, 1'b0, rd, code, lat);
    chk("lb_80_code", {30'b0, code}, 32'd2);
    do_req(1'b0, SZ_W, 1'b0, 32'h7C, 32'h0, 0, 1'b0, rd, code, lat);
    chk("lw_7c_code", {30'b0, code}, 32'd0);

    // Backpressure with a competing request held on the input.
    do_req(1'b0, SZ_W, 1'b0, 32'h8, 32'h0, 3, 1'b1, rd, code, lat);
    chk("bp_rdata", rd, 32'h1299_AABB);
    chk("bp_mem0_kept", mem[0], 32'hDEAD_BEEF);

    // Reset while the sub-word store is in its read phase.
    req_valid = 1'b1; req_we = 1'b1; req_size = SZ_B; req_unsigned = 1'b0;
    req_addr = 32'hB; req_wdata = 32'h34;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    we_start = we_total;
    rst_in = 1'b0;
    @(negedge clk);
    chk("midrst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("midrst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("midrst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("midrst_mem_addr", mem_addr, 32'd0);
    chk("midrst_rdata", resp_rdata, 32'd0);
    rst_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_no_write", we_total - we_start, 0);
    chk("midrst_mem2", mem[2], 32'h1299_AABB);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      we   = 1'($urandom_range(0, 1));
      uns  = 1'($urandom_range(0, 1));
      sz   = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a    = ($urandom_range(0, 5) == 0) ? 32'($urandom_range(0, 255))
                                         : 32'($urandom_range(0, 4 * DEPTH - 1));
      if (sz != 2'd3 && $urandom_range(0, 2) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      poke = ($urandom_range(0, 3) == 0);
      do_req(we, sz, uns, a, $urandom, int'($urandom_range(0, 2)), poke, rd, code, lat);
    end

`ifdef LSU_READBACK_CHECK_EN
    corrupt_en = 1'b1;
    do_req(1'b1, SZ_W, 1'b0, 32'h10, 32'h0000_0001, 0, 1'b0, rd, code, lat);
    chk("rb_corrupt_flag", {31'b0, last_rb}, 32'd1);
    chk("rb_corrupt_lat", lat, 3);
    corrupt_en = 1'b0;
    do_req(1'b1, SZ_W, 1'b0, 32'h10, 32'h0000_0001, 0, 1'b0, rd, code, lat);
    chk("rb_clean_flag", {31'b0, last_rb}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
